// File: rtl/piezo_drv.sv
// Piezo tone/duration generator: differential square wave at note_per cycles,
// single-cycle note_over pulse after note_dur ticks of 1/100 s.
module piezo_drv #(
    parameter int unsigned TICK_CNT = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [14:0] note_per,
    input  logic [7:0]  note_dur,
    output logic        note_over,
    output logic        piezo,
    output logic        piezo_n
);

    localparam int unsigned TICK_W = 19;
    localparam int unsigned DUR_W  = 8;
    localparam int unsigned PER_W  = 15;

    logic [TICK_W-1:0] tick_cnt;
    logic [DUR_W-1:0]  dur_cnt;
    logic [PER_W-1:0]  freq_cnt;

    logic tick_c;
    logic note_end_c;
    logic per_wrap_c;
    logic tone_on_c;
    logic tone_hi_c;

    assign tick_c     = (tick_cnt == TICK_W'(TICK_CNT - 1));
    assign note_end_c = tick_c && (note_dur != '0) &&
                        (dur_cnt == DUR_W'(note_dur - 8'd1));
    // >= rather than == so a mid-note period drop wraps at once
    assign per_wrap_c = (freq_cnt >= PER_W'(note_per - 15'd1));
    assign tone_on_c  = (note_per != '0);
    assign tone_hi_c  = (freq_cnt < {1'b0, note_per[PER_W-1:1]});

    // Counters and registered outputs; clr overrides note-end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            dur_cnt   <= '0;
            freq_cnt  <= '0;
            note_over <= 1'b0;
            piezo     <= 1'b0;
            piezo_n   <= 1'b0;
        end else if (clr) begin
            tick_cnt  <= '0;
            dur_cnt   <= '0;
            freq_cnt  <= '0;
            note_over <= 1'b0;
            piezo     <= 1'b0;
            piezo_n   <= 1'b0;
        end else begin
            piezo   <= tone_on_c && tone_hi_c;
            piezo_n <= tone_on_c && !tone_hi_c;
            if (note_end_c) begin
                // Restart every counter so the next note starts phase-aligned
                tick_cnt  <= '0;
                dur_cnt   <= '0;
                freq_cnt  <= '0;
                note_over <= 1'b1;
            end else begin
                note_over <= 1'b0;
                tick_cnt  <= tick_c ? '0 : tick_cnt + TICK_W'(1);
                dur_cnt   <= tick_c ? dur_cnt + DUR_W'(1) : dur_cnt;
                freq_cnt  <= per_wrap_c ? '0 : freq_cnt + PER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piezo_drv.sv
// Self-checking bench for piezo_drv: vector table, directed corner sequences
// and randomized notes against an arithmetic reference model.
module tb_piezo_drv;

    localparam int unsigned T = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [14:0] note_per;
    logic [7:0]  note_dur;
    logic        note_over;
    logic        piezo;
    logic        piezo_n;

    int n_cmp = 0;
    int n_bad = 0;

    piezo_drv #(.TICK_CNT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .note_per  (note_per),
        .note_dur  (note_dur),
        .note_over (note_over),
        .piezo     (piezo),
        .piezo_n   (piezo_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int dur;
        int ncyc;
        int exp_hi;
        int exp_pulses;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after edge k of a note held constant since counters cleared
    function automatic void model(input int p, input int d, input int k,
                                  output bit po, output bit pn, output bit no);
        int len;
        int m;
        len = d * int'(T);
        no  = (d != 0) && (((k + 1) % len) == 0);
        m   = (d != 0) ? (k % len) : k;
        if (p == 0) begin
            po = 1'b0;
            pn = 1'b0;
        end else begin
            po = ((m % p) < (p / 2));
            pn = !po;
        end
    endfunction

    task automatic check_cycle(input string tag, input int p, input int d, input int k);
        bit po, pn, no;
        model(p, d, k, po, pn, no);
        check($sformatf("%s piezo k=%0d", tag, k), 32'(piezo), 32'(po));
        check($sformatf("%s piezo_n k=%0d", tag, k), 32'(piezo_n), 32'(pn));
        check($sformatf("%s note_over k=%0d", tag, k), 32'(note_over), 32'(no));
    endtask

    task automatic run_note(input string tag, input int p, input int d, input int n,
                            output int hi, output int pulses);
        hi = 0;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            step();
            check_cycle(tag, p, d, k);
            if (k < p && piezo) hi++;
            if (note_over) pulses++;
        end
    endtask

    task automatic start_note(input string tag, input int p, input int d);
        clr = 1'b1;
        note_per = 15'(p);
        note_dur = 8'(d);
        step();
        step();
        check({tag, " clr piezo"}, 32'(piezo), 0);
        check({tag, " clr piezo_n"}, 32'(piezo_n), 0);
        check({tag, " clr note_over"}, 32'(note_over), 0);
        check({tag, " clr counters"}, 32'(dut.tick_cnt) | 32'(dut.dur_cnt) | 32'(dut.freq_cnt), 0);
        clr = 1'b0;
    endtask

    initial begin
        int hi, pulses, cnt, found;
        int seq_per[4];
        int seq_dur[4];
        bit po;

        vt[0] = '{per: 10, dur: 3, ncyc: 100,  exp_hi: 5, exp_pulses: 3};
        vt[1] = '{per: 7,  dur: 0, ncyc: 70,   exp_hi: 3, exp_pulses: 0};
        vt[2] = '{per: 0,  dur: 0, ncyc: 1000, exp_hi: 0, exp_pulses: 0};
        vt[3] = '{per: 10, dur: 0, ncyc: 5000, exp_hi: 5, exp_pulses: 0};
        vt[4] = '{per: 1,  dur: 2, ncyc: 50,   exp_hi: 0, exp_pulses: 2};
        vt[5] = '{per: 3,  dur: 1, ncyc: 60,   exp_hi: 1, exp_pulses: 6};
        seq_per = '{32'h7C90, 32'h6EF9, 32'h62E4, 32'h038E};
        seq_dur = '{32'h40, 32'h20, 32'h10, 32'h20};

        rst = 1'b1;
        clr = 1'b0;
        note_per = 15'd10;
        note_dur = 8'd3;
        step();
        step();
        check("reset piezo", 32'(piezo), 0);
        check("reset piezo_n", 32'(piezo_n), 0);
        check("reset note_over", 32'(note_over), 0);
        rst = 1'b0;

        // Vector table
        foreach (vt[i]) begin
            start_note($sformatf("vec%0d", i), vt[i].per, vt[i].dur);
            run_note($sformatf("vec%0d", i), vt[i].per, vt[i].dur, vt[i].ncyc, hi, pulses);
            check($sformatf("vec%0d high count", i), 32'(hi), 32'(vt[i].exp_hi));
            check($sformatf("vec%0d pulse count", i), 32'(pulses), 32'(vt[i].exp_pulses));
        end

        // Period shrink mid-note
        start_note("shrink", 100, 0);
        for (int k = 0; k < 50; k++) begin
            step();
            check_cycle("shrink", 100, 0, k);
        end
        note_per = 15'd10;
        step();
        check("shrink freq_cnt wrap", 32'(dut.freq_cnt), 0);
        check("shrink piezo k=50", 32'(piezo), 0);
        check("shrink piezo_n k=50", 32'(piezo_n), 1);
        for (int k = 51; k <= 90; k++) begin
            step();
            po = (((k - 51) % 10) < 5);
            check($sformatf("shrink piezo k=%0d", k), 32'(piezo), 32'(po));
            check($sformatf("shrink piezo_n k=%0d", k), 32'(piezo_n), 32'(!po));
        end

        // Asynchronous reset mid-note
        start_note("rst", 10, 3);
        run_note("rst pre", 10, 3, 17, hi, pulses);
        #2 rst = 1'b1;
        #1;
        check("rst async piezo", 32'(piezo), 0);
        check("rst async piezo_n", 32'(piezo_n), 0);
        check("rst async note_over", 32'(note_over), 0);
        check("rst async counters", 32'(dut.tick_cnt) | 32'(dut.dur_cnt) | 32'(dut.freq_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        run_note("rst post", 10, 3, 40, hi, pulses);
        check("rst post high count", 32'(hi), 5);
        check("rst post pulses", 32'(pulses), 1);

        // clr coincident with the note-ending tick
        start_note("clrtick", 10, 1);
        run_note("clrtick pre", 10, 1, 9, hi, pulses);
        check("clrtick tick pending", 32'(dut.tick_cnt), 9);
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("clrtick note_over %0d", k), 32'(note_over), 0);
            check($sformatf("clrtick piezo %0d", k), 32'(piezo) | 32'(piezo_n), 0);
        end
        check("clrtick counters", 32'(dut.tick_cnt) | 32'(dut.dur_cnt) | 32'(dut.freq_cnt), 0);
        clr = 1'b0;
        run_note("clrtick post", 10, 1, 25, hi, pulses);

        // Sequencer loop with hand-off on the edge after note_over
        clr = 1'b1;
        note_per = 15'(seq_per[0]);
        note_dur = 8'(seq_dur[0]);
        step();
        clr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            found = 0;
            while (!found && cnt < 2000) begin
                step();
                cnt++;
                if (note_over) found = 1;
            end
            if (!found) begin
                check($sformatf("seq note %0d timeout", i), 0, 1);
                break;
            end
            check($sformatf("seq note %0d spacing", i), 32'(cnt), 32'(seq_dur[i % 4] * int'(T)));
            step();
            check($sformatf("seq note %0d pulse width", i), 32'(note_over), 0);
            note_per = 15'(seq_per[(i + 1) % 4]);
            note_dur = 8'(seq_dur[(i + 1) % 4]);
            cnt = 1;
        end

        // Randomized notes against the reference model
        for (int s = 0; s < 20; s++) begin
            int p, d, n;
            p = int'($urandom_range(0, 40));
            d = int'($urandom_range(0, 6));
            n = int'($urandom_range(50, 300));
            start_note($sformatf("rnd%0d", s), p, d);
            run_note($sformatf("rnd%0d p=%0d d=%0d", s, p, d), p, d, n, hi, pulses);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
